serial_mag_comparator: RTL and testbench

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

---
 rtl/serial_mag_comparator_pkg.sv | 15 +
 rtl/serial_mag_comparator_bit_cmp_cell.sv | 20 ++
 rtl/serial_mag_comparator.sv | 92 +++++++++
 tb/tb_serial_mag_comparator.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_mag_comparator_pkg.sv
// Shared definitions for the serial magnitude comparator.
// These cover the FSM state encoding and the one-hot result codes.
package serial_mag_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

endpackage

// File: rtl/serial_mag_comparator_bit_cmp_cell.sv
// Single-bit magnitude compare cell.
// The output uses the same one-hot GT/EQ/LT encoding as the comparator result.
module bit_cmp_cell
    import serial_mag_comparator_pkg::*;
(
    input  logic       a,
    input  logic       b,
    output logic [2:0] y
);

    always_comb begin
        y = EQ;
        if (a && !b) begin
            y = GT;
        end else if (!a && b) begin
            y = LT;
        end
    end

endmodule

// File: rtl/serial_mag_comparator.sv
// MSB-first serial magnitude comparator.
// It stops early on the first differing bit and pulses done for one cycle.
module serial_mag_comparator
    import serial_mag_comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [2:0]       y
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state, state_n;
    logic [WIDTH-1:0]   sa, sa_n;
    logic [WIDTH-1:0]   sb, sb_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2:0]         y_n;
    logic [2:0]         bit_y;

    bit_cmp_cell u_cell (
        .a (sa[WIDTH-1]),
        .b (sb[WIDTH-1]),
        .y (bit_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            y     <= '0;
        end else begin
            state <= state_n;
            sa    <= sa_n;
            sb    <= sb_n;
            cnt   <= cnt_n;
            y     <= y_n;
        end
    end

    always_comb begin
        state_n = state;
        sa_n    = sa;
        sb_n    = sb;
        cnt_n   = cnt;
        y_n     = y;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sa_n    = a;
                    sb_n    = b;
                    cnt_n   = CNT_W'(WIDTH - 1);
                    state_n = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // A differing MSB decides the result; otherwise walk down one bit.
                if (bit_y != EQ) begin
                    y_n     = bit_y;
                    state_n = DONE;
                end else if (cnt != '0) begin
                    sa_n  = {sa[WIDTH-2:0], 1'b0};
                    sb_n  = {sb[WIDTH-2:0], 1'b0};
                    cnt_n = cnt - 1'b1;
                end else begin
                    y_n     = EQ;
                    state_n = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench for serial_mag_comparator.
// It checks latency, result, busy/done framing, ignored start and async reset.
module tb_serial_mag_comparator;

    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [2:0]  y;
        int unsigned k;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [2:0]       y;

    int unsigned vectors;
    int unsigned miscompares;
    int unsigned cyc;
    logic [2:0]  last_y;
    exp_t        sb_q[$];

    serial_mag_comparator #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: scan MSB-first for the first differing bit.
    function automatic exp_t model(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        exp_t e;
        bit   found;
        e.k   = WIDTH;
        e.y   = 3'b010;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && (va[i] != vb[i])) begin
                found = 1'b1;
                e.k   = WIDTH - i;
                e.y   = va[i] ? 3'b100 : 3'b001;
            end
        end
        return e;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #3;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        vectors++;
        if (y !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_y: got %b want 000", y);
        end
        last_y = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_hold;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0 || y !== last_y) begin
                miscompares++;
                $display("FAIL idle_hold: busy=%b done=%b y=%b want busy=0 done=0 y=%b",
                         busy, done, y, last_y);
            end
        end
    endtask

    task automatic do_cmp(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input bit poke, input string tag);
        exp_t        e;
        int unsigned c0;
        bit          seen;
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0    = cyc;
        sb_q.push_back(model(va, vb));
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
        end
        seen = 1'b0;
        for (int unsigned n = 1; n <= WIDTH + 3 && !seen; n++) begin
            @(negedge clk);
            if (poke) begin
                if (n == 1) begin
                    start = 1'b1;
                    a     = '1;
                    b     = '0;
                end else if (n == 2) begin
                    start = 1'b0;
                end
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s unexpected_done: got done=1 want no pending result", tag);
                end else begin
                    e = sb_q.pop_front();
                    vectors++;
                    if (cyc - c0 != e.k) begin
                        miscompares++;
                        $display("FAIL %s latency: got %0d want %0d", tag, cyc - c0, e.k);
                    end
                    if (y !== e.y) begin
                        miscompares++;
                        $display("FAIL %s result: got %b want %b", tag, y, e.y);
                    end
                    last_y = e.y;
                end
            end else begin
                vectors++;
                if (busy !== 1'b1 || y !== last_y) begin
                    miscompares++;
                    $display("FAIL %s run_hold: busy=%b y=%b want busy=1 y=%b",
                             tag, busy, y, last_y);
                end
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: got no done want done within %0d cycles", tag, WIDTH + 3);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || y !== last_y) begin
            miscompares++;
            $display("FAIL %s after_done: done=%b busy=%b y=%b want done=0 busy=0 y=%b",
                     tag, done, busy, y, last_y);
        end
    endtask

    task automatic test_basic;
        do_cmp(8'hA5, 8'hA5, 1'b0, "eq_a5");
        do_cmp(8'h80, 8'h7F, 1'b0, "gt_msb");
        do_cmp(8'h00, 8'h01, 1'b0, "lt_lsb");
        do_cmp(8'h10, 8'h30, 1'b0, "lt_bit5");
        do_cmp(8'hFF, 8'hFE, 1'b0, "gt_lsb");
    endtask

    task automatic test_ignore_start;
        do_cmp(8'hA5, 8'hA5, 1'b1, "ignore_eq");
        do_cmp(8'h10, 8'h30, 1'b1, "ignore_lt");
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        a     = 8'hF0;
        b     = 8'hF1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_run_reset: busy=%b done=%b y=%b want 0 0 000", busy, done, y);
        end
        last_y = 3'b000;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold: done=%b busy=%b want 0 0", done, busy);
            end
        end
        rst_n = 1'b1;
        repeat (WIDTH + 2) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || y !== 3'b000) begin
                miscompares++;
                $display("FAIL aborted_no_done: done=%b y=%b want 0 000", done, y);
            end
        end
        do_cmp(8'hF0, 8'hF1, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] pa[3];
        logic [WIDTH-1:0] pb[3];
        exp_t             e;
        int unsigned      c0;
        int unsigned      prev_done;
        bit               seen;
        pa[0] = 8'h3C; pb[0] = 8'h3C;
        pa[1] = 8'h80; pb[1] = 8'h01;
        pa[2] = 8'h40; pb[2] = 8'h60;
        prev_done = 0;
        @(negedge clk);
        a     = pa[0];
        b     = pb[0];
        start = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            c0 = cyc;
            sb_q.push_back(model(pa[i], pb[i]));
            // Next operands are presented during RUN; they must not disturb this result.
            if (i < 2) begin
                a = pa[i+1];
                b = pb[i+1];
            end
            seen = 1'b0;
            for (int unsigned n = 1; n <= WIDTH + 3 && !seen; n++) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    seen = 1'b1;
                    e = sb_q.pop_front();
                    vectors++;
                    if (cyc - c0 != e.k || y !== e.y) begin
                        miscompares++;
                        $display("FAIL b2b_%0d result: lat=%0d y=%b want lat=%0d y=%b",
                                 i, cyc - c0, y, e.k, e.y);
                    end
                    if (i > 0) begin
                        vectors++;
                        if (cyc - prev_done != e.k + 2) begin
                            miscompares++;
                            $display("FAIL b2b_%0d spacing: got %0d want %0d",
                                     i, cyc - prev_done, e.k + 2);
                        end
                    end
                    prev_done = cyc;
                    last_y    = e.y;
                end
            end
            if (!seen) begin
                vectors++;
                miscompares++;
                $display("FAIL b2b_%0d timeout: got no done want done", i);
            end
            if (i == 2) start = 1'b0;
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_%0d idle_gap: busy=%b done=%b want 0 0", i, busy, done);
            end
        end
        test_idle_hold();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        test_reset();
        test_idle_hold();
        test_basic();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
